// File: rtl/mdu_issue_ctrl.sv
// Issue/sequencing controller for the MIPS multiply/divide unit: starts mult/div,
// counts their latency, fires the HI/LO commit and raises the D-stage stall.
module mdu_issue_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] e_op,
   input  logic       e_valid,
   input  logic       req,
   input  logic [3:0] d_op,
   output logic       issue,
   output logic       wr_hi,
   output logic       wr_lo,
   output logic       commit,
   output logic       busy,
   output logic       stall,
   output logic       kind
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_e;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       kind_q, kind_d;

   logic       go_s;
   logic       is_mul_s;
   logic       is_div_s;
   logic       d_mdu_s;

   assign go_s     = e_valid && !req && (state_q == ST_IDLE);
   assign is_mul_s = (e_op == 4'd1) || (e_op == 4'd2);
   assign is_div_s = (e_op == 4'd3) || (e_op == 4'd4);
   assign d_mdu_s  = (d_op >= 4'd1) && (d_op <= 4'd8);

   // State, latency counter and op-class registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         kind_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kind_q  <= kind_d;
      end
   end

   // Next-state: load the latency on issue, count down to the commit cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      kind_d  = kind_q;
      case (state_q)
         ST_IDLE: begin
            if (go_s && is_mul_s) begin
               state_d = ST_MUL;
               cnt_d   = MULT_LOAD;
               kind_d  = 1'b0;
            end else if (go_s && is_div_s) begin
               state_d = ST_DIV;
               cnt_d   = DIV_LOAD;
               kind_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL, ST_DIV: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Outputs: issue/moves only when idle and not flushed; commit on the last busy cycle
   always_comb begin
      issue  = 1'b0;
      wr_hi  = 1'b0;
      wr_lo  = 1'b0;
      commit = 1'b0;
      case (state_q)
         ST_IDLE: begin
            issue = go_s && (is_mul_s || is_div_s);
            wr_hi = go_s && (e_op == 4'd7);
            wr_lo = go_s && (e_op == 4'd8);
         end
         ST_MUL, ST_DIV: begin
            commit = (cnt_q == 4'd0);
         end
         default: begin
            commit = 1'b0;
         end
      endcase
      busy  = (state_q != ST_IDLE);
      // HI/LO are written at the end of commit, so a D-stage MDU op may advance then
      stall = d_mdu_s && (issue || (busy && !commit));
      kind  = kind_q;
   end

endmodule

// File: doc/mdu_issue_ctrl.md
# mdu_issue_ctrl

Issue and sequencing controller for the multiply/divide unit (MDU) in the pipelined MIPS core. It decides when an E-stage MDU instruction starts and when a result commits to HI/LO. It counts the multi-cycle latency of mult and div. It raises the D-stage stall whenever a following MDU instruction would observe stale HI/LO or collide with a computation in flight. The arithmetic and the HI/LO registers live in the MDU datapath; this block drives that datapath's enables.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu; legal range 1..15
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- e_op  in  4  E-stage MDU op: 0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; values 9..15 are treated as nop
- e_valid  in  1  E-stage slot holds a real instruction (not a bubble)
- req  in  1  exception/interrupt flush; the E-stage instruction is cancelled this cycle
- d_op  in  4  D-stage MDU op, same encoding as e_op
- issue  out  1  combinational pulse; the datapath latches operands and computes into tmpHI/tmpLO
- wr_hi  out  1  combinational; HI <= rs at the end of this cycle (mthi)
- wr_lo  out  1  combinational; LO <= rs at the end of this cycle (mtlo)
- commit  out  1  combinational pulse; HI/LO <= tmpHI/tmpLO at the end of this cycle
- busy  out  1  a computation is in flight
- stall  out  1  D-stage stall request
- kind  out  1  in-flight op class: 0 mult, 1 div; held after completion

## Operation
- State machine:
  - IDLE, MUL, DIV.
  - 4-bit down-counter cnt.
- go = e_valid && !req && (state == IDLE).
- IDLE:
  - go && e_op in {1,2}: issue=1; next state MUL; cnt <= MULT_CYCLES-1; kind <= 0.
  - go && e_op in {3,4}: issue=1; next state DIV; cnt <= DIV_CYCLES-1; kind <= 1.
  - go && e_op==7: wr_hi=1. go && e_op==8: wr_lo=1. State stays IDLE.
  - mfhi/mflo/nop: no control action.
- MUL/DIV:
  - cnt != 0: cnt <= cnt-1.
  - cnt == 0: commit=1; next state IDLE.
- busy = (state != IDLE).
- While busy, e_op is ignored. issue, wr_hi and wr_lo stay 0. The stall makes an MDU op in E during busy unreachable; the bench asserts it never occurs.
- req has no effect on an in-flight computation. An issued op always commits. req only suppresses issue, wr_hi and wr_lo in the cycle it is high.
- stall = (d_op in 1..8) && (issue || (busy && !commit)).
  - HI/LO update at the end of the commit cycle, so a D-stage op may advance during commit.
  - That op reaches E in an IDLE cycle, which allows back-to-back MDU ops.
- reset mid-operation: state <= IDLE, cnt <= 0, kind <= 0. No commit pulse is produced, and the pending result is discarded.

## Timing
- Reset values: state IDLE, cnt 0, kind 0. Outputs issue, wr_hi, wr_lo, commit, busy and stall are all 0 while d_op/e_op are nop.
- With issue in cycle t:
  - busy is high in cycles t+1 .. t+N, where N = MULT_CYCLES or DIV_CYCLES.
  - commit is high in cycle t+N only.
  - The next issue can occur no earlier than t+N+1.
- With N=1: busy and commit are both high in cycle t+1 only.
- wr_hi/wr_lo take effect in the same cycle as e_op, with zero latency; they never stall.
- issue, wr_*, commit and stall are combinational from state, cnt, e_op, e_valid, req and d_op. There is no combinational path from commit back to issue.

## Test plan
- Reset, then all inputs nop: issue=wr_hi=wr_lo=commit=busy=stall=0 and kind=0 every cycle.
- mult issued at cycle 0 (e_valid=1, req=0) with d_op=6 (mflo) held throughout:
  - issue=1 at cycle 0 only.
  - busy=1 in cycles 1..5.
  - commit=1 at cycle 5 only.
  - stall=1 in cycles 0..4 and 0 from cycle 5.
  - kind=0.
- divu issued at cycle 0, default parameters: busy in cycles 1..10, commit at cycle 10, kind=1. A mult presented in E at cycle 11 issues at cycle 11.
- req=1 with e_op=3, e_valid=1: issue=0 and busy stays 0. The same cycle with e_op=7: wr_hi=0.
- req=1 at cycle 3 of an in-flight mult: commit still pulses at cycle 5 and busy drops at cycle 6. reset at cycle 3 instead: busy=0 from cycle 4 and commit never pulses.
- mthi with e_valid=1, d_op=5: wr_hi=1 the same cycle, busy=0 and stall=0. e_op=9 gives no output activity.
